stream_demux: RTL

Registered 1-to-N stream demultiplexer: one valid/ready input stream carrying a data word plus a destination selector, routed to one of N independent valid/ready output channels. It is the counterpart of the team's 8-channel 32-bit mux and sits on the fan-out side of the same datapath. Each output channel has a one-entry holding register. A stalled channel therefore back-pressures only words addressed to it.

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/demux_slot.sv | 53 +++++
 rtl/stream_demux.sv | 86 ++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer and its per-channel slots.
package stream_demux_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_N_CH       = 8;
    localparam int SEL_W          = 3;
    localparam int DROP_CNT_W     = 16;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready output handshake for a single channel.
//
// state    | meaning
// CH_EMPTY | no word held, output valid low
// CH_FULL  | word held in data_q, presented until the consumer takes it
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  free_o
);

    ch_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  drain;

    assign drain = (state_q == CH_FULL) & ready_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            // a load on a draining cycle replaces the word in place, so no bubble
            state_d = CH_FULL;
            data_d  = data_i;
        end else if (drain) begin
            state_d = CH_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == CH_FULL);
    assign data_o  = data_q;
    assign free_o  = (state_q == CH_EMPTY) | ready_i;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: selector decode, input ready mux and
// a saturating counter of words dropped for out-of-range selectors.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_CH       = DEF_N_CH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [SEL_W-1:0]           selector_i,
    input  logic [DATA_WIDTH-1:0]      channel_in_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [N_CH*DATA_WIDTH-1:0] ch_data_o,
    output logic [N_CH-1:0]            ch_valid_o,
    input  logic [N_CH-1:0]            ch_ready_i,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o,
    output logic                       busy_o
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

    logic                  sel_legal;
    logic                  sel_free;
    logic                  accept;
    logic [N_CH-1:0]       slot_free;
    logic [N_CH-1:0]       slot_load;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign sel_legal = ({1'b0, selector_i} < N_CH_W);

    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (selector_i == SEL_W'(k)) begin
                sel_free = slot_free[k];
            end
        end
    end

    // out-of-range words are always accepted so they can be discarded
    assign ready_o = ~rst_i & (~sel_legal | sel_free);
    assign accept  = valid_i & ready_o;

    always_comb begin
        slot_load = '0;
        for (int k = 0; k < N_CH; k++) begin
            slot_load[k] = accept & (selector_i == SEL_W'(k));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (slot_load[g]),
            .data_i  (channel_in_i),
            .ready_i (ch_ready_i[g]),
            .valid_o (ch_valid_o[g]),
            .data_o  (ch_data_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .free_o  (slot_free[g])
        );
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept & ~sel_legal & ~(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign busy_o     = |ch_valid_o;

endmodule
